serial_word_collector: RTL and testbench

SERIAL_WORD_COLLECTOR -- requirements
Module: serial_word_collector

---
 rtl/serial_word_collector_pkg.sv | 13 +
 rtl/serial_word_collector_shift.sv | 35 +++
 rtl/serial_word_collector.sv | 142 ++++++++++++++
 tb/tb_serial_word_collector.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_collector_pkg.sv
// Shared types for the serial word collector: collector FSM states and
// status-bit positions within the sticky status output.
package serial_word_collector_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int OVF  = 0;
    localparam int FERR = 1;

endpackage

// File: rtl/serial_word_collector_shift.sv
// W-bit serial-in/parallel-out shift register. shifted_o is the value the
// register takes on this edge when shift_en_i is high.
module word_shift_reg #(
    parameter int W         = 31,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk_i,
    input  logic         rstb_i,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [W-1:0] shifted_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // MSB-first pushes toward the top so the first bit ends in the MSB.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_o = {sr_q[W-2:0], bit_i};
        end else begin
            shifted_o = {bit_i, sr_q[W-1:1]};
        end
        sr_d = shift_en_i ? shifted_o : sr_q;
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Collects framed serial bits into W-bit words and presents them through a
// one-deep valid/ready holding register with sticky overflow/frame-error bits.
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  atpg,
    input  logic                  i,
    input  logic                  a,
    input  logic                  c,
    input  logic                  r,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:1] q,
    output logic                  o,
    output logic [1:0]            b
);

    localparam int W  = DATA_WIDTH - 1;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    // Handshake: the word in q is taken on any edge where o=1 and r=1;
    // q never changes while o=1 and r=0.
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  word_q, word_d;
    logic          valid_q, valid_d;
    logic [1:0]    status_q, status_d;

    logic          shift_en;
    logic [W-1:0]  sr_next;
    logic          word_done;
    logic          ovf_set;
    logic          ferr_set;
    logic          consume;

    word_shift_reg #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_i      (clk),
        .rstb_i     (rstb),
        .shift_en_i (shift_en),
        .bit_i      (i),
        .shifted_o  (sr_next)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        word_d    = word_q;
        valid_d   = valid_q;
        status_d  = status_q;
        shift_en  = 1'b0;
        word_done = 1'b0;
        ovf_set   = 1'b0;
        ferr_set  = 1'b0;
        consume   = valid_q & r;

        if (atpg) begin
            // Scan mode: free-running shift mirrored onto q, nothing pending.
            shift_en = 1'b1;
            state_d  = IDLE;
            count_d  = '0;
            valid_d  = 1'b0;
            word_d   = sr_next;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a && c) begin
                        shift_en = 1'b1;
                        count_d  = ONE_CNT;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (a) begin
                        shift_en = 1'b1;
                        if (c) begin
                            ferr_set = 1'b1;
                            count_d  = ONE_CNT;
                        end else if (count_q == LAST_CNT) begin
                            word_done = 1'b1;
                            count_d   = '0;
                            state_d   = IDLE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (word_done) begin
                if (!valid_q || r) begin
                    word_d  = sr_next;
                    valid_d = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (consume) begin
                valid_d = 1'b0;
            end

            if (clr) begin
                status_d = '0;
            end
            if (ovf_set) begin
                status_d[OVF] = 1'b1;
            end
            if (ferr_set) begin
                status_d[FERR] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            count_q  <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            status_q <= status_d;
        end
    end

    assign q = word_q;
    assign o = valid_q;
    assign b = status_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: MSB-first and LSB-first instances share
// stimulus; a frame-level model feeds per-instance expected-word queues.
module tb_serial_word_collector;

    localparam int DW = 9;
    localparam int W  = DW - 1;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic atpg = 1'b0;
    logic i_bit = 1'b0;
    logic a = 1'b0;
    logic c = 1'b0;
    logic r = 1'b0;
    logic clr = 1'b0;

    logic [W-1:0] q_m, q_l;
    logic         o_m, o_l;
    logic [1:0]   b_m, b_l;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q_m[$];
    logic [W-1:0] exp_q_l[$];

    // Frame-level reference state
    logic         m_in_frame;
    logic         bits[$];
    logic         m_valid;
    logic [1:0]   m_status;

    serial_word_collector #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rstb(rstb), .atpg(atpg), .i(i_bit), .a(a), .c(c),
        .r(r), .clr(clr), .q(q_m), .o(o_m), .b(b_m)
    );

    serial_word_collector #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rstb(rstb), .atpg(atpg), .i(i_bit), .a(a), .c(c),
        .r(r), .clr(clr), .q(q_l), .o(o_l), .b(b_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 1'b0;
        bits.delete();
        m_valid = 1'b0;
        m_status = 2'b00;
        exp_q_m.delete();
        exp_q_l.delete();
    endfunction

    // Applies one clock edge's worth of inputs to the frame-level model.
    function automatic void model_step(input logic a_v, input logic c_v, input logic i_v,
                                       input logic r_v, input logic clr_v, input logic atpg_v);
        logic done;
        logic ovf;
        logic ferr;
        logic [W-1:0] w_m;
        logic [W-1:0] w_l;
        done = 1'b0;
        ovf  = 1'b0;
        ferr = 1'b0;
        if (atpg_v) begin
            m_in_frame = 1'b0;
            bits.delete();
            m_valid = 1'b0;
            exp_q_m.delete();
            exp_q_l.delete();
            return;
        end
        if (a_v) begin
            if (c_v) begin
                ferr = m_in_frame;
                bits.delete();
                bits.push_back(i_v);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                bits.push_back(i_v);
                if (bits.size() == W) begin
                    done = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
        if (done) begin
            if (!m_valid || r_v) begin
                for (int k = 0; k < W; k++) begin
                    w_m[W-1-k] = bits[k];
                    w_l[k] = bits[k];
                end
                exp_q_m.push_back(w_m);
                exp_q_l.push_back(w_l);
                m_valid = 1'b1;
            end else begin
                ovf = 1'b1;
            end
            bits.delete();
        end else if (m_valid && r_v) begin
            m_valid = 1'b0;
        end
        if (clr_v) m_status = 2'b00;
        m_status = m_status | {ferr, ovf};
    endfunction

    task automatic cyc(input logic a_v, input logic c_v, input logic i_v,
                       input logic r_v, input logic clr_v, input logic atpg_v);
        a = a_v; c = c_v; i_bit = i_v; r = r_v; clr = clr_v; atpg = atpg_v;
        @(posedge clk);
        model_step(a_v, c_v, i_v, r_v, clr_v, atpg_v);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic r_v, input logic lsb_first);
        logic bv;
        for (int k = 0; k < W; k++) begin
            bv = lsb_first ? w[k] : w[W-1-k];
            cyc(1'b1, k == 0, bv, r_v, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rstb = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    // Monitor: status every cycle, words whenever a handshake is presented.
    always @(negedge clk) begin
        if (rstb) begin
            chk("o_msb", o_m, m_valid);
            chk("b_msb", b_m, m_status);
            chk("o_lsb", o_l, m_valid);
            chk("b_lsb", b_l, m_status);
            if (o_m && r) begin
                if (exp_q_m.size() == 0) chk("q_msb_unexpected", 1, 0);
                else chk("q_msb", q_m, exp_q_m.pop_front());
            end
            if (o_l && r) begin
                if (exp_q_l.size() == 0) chk("q_lsb_unexpected", 1, 0);
                else chk("q_lsb", q_l, exp_q_l.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] scan_bits;
        logic       cv;
        int         n;
        model_reset();
        rstb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        chk("reset_q", q_m, 0);
        chk("reset_o", o_m, 0);
        chk("reset_b", b_m, 0);

        // Basic frame, palindrome on the LSB-first instance
        send_word(8'hA5, 1'b1, 1'b0);
        chk("a5_q_msb", q_m, 8'hA5);
        chk("a5_q_lsb", q_l, 8'hA5);
        chk("a5_o", o_m, 1);
        chk("a5_b", b_m, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("a5_o_one_cycle", o_m, 0);

        send_word(8'h01, 1'b1, 1'b1);
        chk("01_q_lsb", q_l, 8'h01);
        chk("01_q_msb", q_m, 8'h80);
        cyc(0, 0, 0, 1, 0, 0);

        // Overflow: second word dropped while first is unacknowledged
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ovf_q", q_m, 8'h3C);
        chk("ovf_o", o_m, 1);
        chk("ovf_b", b_m, 2'b01);
        cyc(0, 0, 0, 1, 0, 0);
        chk("ovf_o_cleared", o_m, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("clr_b", b_m, 0);

        // Frame error: restart on the fifth strobe
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 0, 1, 1, 0, 0);
        chk("ferr_q", q_m, 8'hFF);
        chk("ferr_b", b_m, 2'b10);
        chk("ferr_o", o_m, 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("ferr_clr_b", b_m, 0);

        // Reset mid-frame
        for (int k = 0; k < 4; k++) cyc(1, k == 0, 1, 1, 0, 0);
        pulse_reset();
        chk("rst_q", q_m, 0);
        chk("rst_o", o_m, 0);
        send_word(8'h5A, 1'b1, 1'b0);
        chk("rst_5a_q", q_m, 8'h5A);
        chk("rst_5a_b", b_m, 0);
        cyc(0, 0, 0, 1, 0, 0);

        // Scan mode with a sticky error set and a partial frame in flight
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 0);
        scan_bits = 8'b1100_1100;
        for (int k = 0; k < 8; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), scan_bits[7-k], 1, 1, 1);
        end
        chk("scan_q_msb", q_m, 8'hCC);
        chk("scan_q_lsb", q_l, 8'h33);
        chk("scan_o", o_m, 0);
        chk("scan_b_hold", b_m, 2'b10);
        for (int k = 0; k < W + 2; k++) cyc(1, 0, 1'($urandom_range(0, 1)), 1, 0, 0);
        chk("post_scan_no_word", o_m, 0);
        cyc(0, 0, 0, 1, 1, 0);

        // Randomized framing, gaps, back-pressure, restarts and clears
        for (int f = 0; f < 60; f++) begin
            n = W + int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                cv = (k == 0) || ($urandom_range(0, 11) == 0);
                while ($urandom_range(0, 2) == 0) begin
                    cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
                end
                cyc(1, cv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 19) == 0, 0);
            end
        end

        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0, 0);
        chk("drain_msb", exp_q_m.size(), 0);
        chk("drain_lsb", exp_q_l.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
